// File: rtl/dfs_lut_fetch.sv
// rtl/dfs_lut_fetch.sv - DFS lookup-table fetch front end with last-index cache
//
// Reads the MMCM lookup BRAM (36 bit) and the achieved-frequency BRAM (18 bit)
// at a requested table index in parallel. It unpacks the fields, sanity-checks
// them, and presents them on a valid/ready output. A one-entry cache of the
// last good index lets a repeated request skip the BRAM read.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       invalidate the cache (pulse after table rewrite)
//   req_valid/req_ready/req_addr  request handshake and table index
//   bram36_en/addr/dout         lookup BRAM read port
//   bram18_en/addr/dout         frequency BRAM read port
//   cfg_valid/cfg_ready         output handshake
//   cfg_lookup_int .. cfg_freq  unpacked entry fields
//   cfg_err                     entry failed the sanity check (qualified by cfg_valid)

module dfs_lut_fetch #(
  parameter int RD_LAT   = 1,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_addr,
  output logic        bram36_en,
  output logic [9:0]  bram36_addr,
  input  logic [35:0] bram36_dout,
  output logic        bram18_en,
  output logic [9:0]  bram18_addr,
  input  logic [17:0] bram18_dout,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [9:0]  cfg_lookup_int,
  output logic [2:0]  cfg_shift,
  output logic [5:0]  cfg_mult,
  output logic [5:0]  cfg_div,
  output logic [5:0]  cfg_odiv_int,
  output logic [2:0]  cfg_odiv_frac,
  output logic        cfg_frac_en,
  output logic [12:0] cfg_freq,
  output logic        cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CAPT = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Last wait-counter value in CAPT: the BRAM output is valid once the
  // counter reaches RD_LAT-1 cycles after the READ cycle.
  localparam logic LAT_LAST = 1'(RD_LAT == 2);

  state_t      state;
  state_t      state_nx;
  logic        lat_cnt;
  logic [9:0]  rd_addr;
  logic [47:0] out_data;
  logic        out_err;
  logic        cache_vld;
  logic [9:0]  cache_addr;
  logic [47:0] cache_data;
  logic        no_fill;

  logic        accept;
  logic        hit;
  logic        capt_now;
  logic [47:0] entry_data;
  logic        entry_err;
  logic        unused_bits;

  // Packed entry layout: {lookup_int, shift, M, D, O_int, O_frac, O_frac_en, freq}
  assign entry_data = {bram36_dout[35:1], bram18_dout[17:5]};

  assign entry_err = (bram36_dout[22:17] == 6'd0)
                   | (bram36_dout[16:11] == 6'd0)
                   | (bram36_dout[10:5]  == 6'd0)
                   | (bram36_dout[1] & (bram36_dout[10:5] < 6'd2))
                   | (bram18_dout[17:5]  == 13'd0);

  assign unused_bits = ^{bram36_dout[0], bram18_dout[4:0]};

  assign req_ready = (state == IDLE) & ~rst;
  assign accept    = req_valid & req_ready;
  // A flush in the same cycle as the request wins over the cached copy.
  assign hit       = CACHE_EN & cache_vld & (req_addr == cache_addr) & ~flush;
  assign capt_now  = (state == CAPT) & (lat_cnt == LAT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = hit ? OUT : READ;
      READ: state_nx = CAPT;
      CAPT: if (capt_now) state_nx = OUT;
      OUT:  if (cfg_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= 1'b0;
      rd_addr    <= '0;
      out_data   <= '0;
      out_err    <= 1'b0;
      cache_vld  <= 1'b0;
      cache_addr <= '0;
      cache_data <= '0;
      no_fill    <= 1'b0;
    end else begin
      state   <= state_nx;
      lat_cnt <= ((state == CAPT) && !capt_now) ? 1'b1 : 1'b0;

      if (accept && !hit) rd_addr <= req_addr;

      if (accept && hit) begin
        out_data <= cache_data;
        out_err  <= 1'b0;
      end else if (capt_now) begin
        out_data <= entry_data;
        out_err  <= entry_err;
      end

      // A flush that lands while a read is in flight must keep that
      // (possibly stale) data out of the cache.
      if (flush && ((state == READ) || (state == CAPT))) no_fill <= 1'b1;
      else if (state == IDLE)                             no_fill <= 1'b0;

      if (flush) begin
        cache_vld <= 1'b0;
      end else if (capt_now) begin
        if (entry_err) begin
          cache_vld <= 1'b0;
        end else if (CACHE_EN && !no_fill) begin
          cache_vld  <= 1'b1;
          cache_addr <= rd_addr;
          cache_data <= entry_data;
        end
      end
    end
  end

  assign bram36_en   = (state == READ);
  assign bram18_en   = (state == READ);
  assign bram36_addr = rd_addr;
  assign bram18_addr = rd_addr;

  assign cfg_valid      = (state == OUT);
  assign cfg_lookup_int = out_data[47:38];
  assign cfg_shift      = out_data[37:35];
  assign cfg_mult       = out_data[34:29];
  assign cfg_div        = out_data[28:23];
  assign cfg_odiv_int   = out_data[22:17];
  assign cfg_odiv_frac  = out_data[16:14];
  assign cfg_frac_en    = out_data[13];
  assign cfg_freq       = out_data[12:0];
  assign cfg_err        = out_err;

endmodule
